// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) that sits beside execute.
// result_o = {remainder, quotient}; ready_o holds until execute drops start_i.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {S_FREE, S_ON, S_DBZ, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2*WIDTH:0]     work, work_n;
  logic [WIDTH-1:0]     divisor, divisor_n;
  logic                 sgn, sgn_n;
  logic                 neg1, neg1_n;
  logic                 neg2, neg2_n;
  logic [2*WIDTH-1:0]   result_n;
  logic                 ready_n;

  logic [WIDTH-1:0]     op1_abs, op2_abs;
  logic [WIDTH-1:0]     quot, rem;
  logic [WIDTH:0]       diff;

  // work[2W:W+1] is the partial remainder, work[W] the next dividend bit to
  // bring down, so work[2W:W] is already the shifted remainder (W+1 bits).
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    diff    = work[2*WIDTH:WIDTH] - {1'b0, divisor};
    quot    = (sgn && (neg1 ^ neg2)) ? ('0 - work[WIDTH-1:0]) : work[WIDTH-1:0];
    rem     = (sgn && neg1) ? ('0 - work[2*WIDTH:WIDTH+1]) : work[2*WIDTH:WIDTH+1];
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    sgn_n     = sgn;
    neg1_n    = neg1;
    neg2_n    = neg2;
    result_n  = result_o;
    ready_n   = ready_o;
    case (state)
      S_FREE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = S_DBZ;
          end else begin
            state_n   = S_ON;
            cnt_n     = '0;
            work_n    = {{WIDTH{1'b0}}, op1_abs, 1'b0};
            divisor_n = op2_abs;
            sgn_n     = signed_div_i;
            neg1_n    = opdata1_i[WIDTH-1];
            neg2_n    = opdata2_i[WIDTH-1];
          end
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_n  = S_FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt != LAST) begin
          if (diff[WIDTH]) begin
            work_n = {work[2*WIDTH-1:0], 1'b0};
          end else begin
            work_n = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          end
          cnt_n = cnt + CNT_W'(1);
        end else begin
          result_n = {rem, quot};
          ready_n  = 1'b1;
          state_n  = S_END;
        end
      end
      S_DBZ: begin
        if (annul_i) begin
          state_n  = S_FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end else begin
          result_n = '0;
          ready_n  = 1'b1;
          state_n  = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_n  = S_FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      sgn      <= sgn_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency,
// divide-by-zero, annul, mid-operation reset and END-state hold behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int compared   = 0;
  int mismatched = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: start, count edges to ready, check hold in END, then release.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat);
    int n;
    logic [63:0] held;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 3) begin
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~sg;
      end
      if (ready_o) break;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
    held = result_o;
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, held);
    start_i = 1'b0;
    tick();
    check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    int rises;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
    run_div("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34);
    run_div("udiv_big_div", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd0}, 34);
    run_div("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 34);
    run_div("dbz", 1'b1, 32'h1234_5678, 32'd0, 64'd0, 2);

    // Annul partway through the iterations.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    rises = 0;
    repeat (40) begin
      tick();
      if (ready_o) rises++;
    end
    check("annul_no_ready", 64'(rises), 64'd0);
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Reset partway through the iterations.
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFF_FFF9;
    opdata2_i    = 32'd2;
    start_i      = 1'b1;
    repeat (21) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    rises = 0;
    repeat (40) begin
      tick();
      if (ready_o) rises++;
    end
    check("midrst_no_ready", 64'(rises), 64'd0);
    run_div("after_rst_udiv", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
